demux2_stream: RTL and testbench
================================

Name: demux2_stream

Overview:
- Registered 1:2 stream demultiplexer: the receive-side counterpart of the team's 2:1 mux.
- Accepts one input word stream tagged with a select bit and routes each word to output channel 0 or 1.
- Each output has its own small FIFO, so a stalled channel does not block words bound for the other channel once they are accepted.
- Sits at the far end of a muxed link and restores the two original streams with valid/ready handshakes.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 4: entries per output FIFO; power of two, >= 2.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  WIDTH  input word
- in_sel  in  1  destination: 0 -> channel 0, 1 -> channel 1
- in_valid  in  1  input word/sel valid
- in_ready  out  1  demux can accept the word on in_data/in_sel
- out0_data  out  WIDTH  channel 0 head word
- out0_valid  out  1  channel 0 FIFO non-empty
- out0_ready  in  1  channel 0 consumer accepts head word
- out1_data  out  WIDTH  channel 1 head word
- out1_valid  out  1  channel 1 FIFO non-empty
- out1_ready  in  1  channel 1 consumer accepts head word
- out0_level  out  $clog2(DEPTH)+1  channel 0 occupancy
- out1_level  out  $clog2(DEPTH)+1  channel 1 occupancy

Behaviour:
- Reset (rst_n low, asynchronous): both FIFOs empty; pointers and levels 0; out*_valid=0; out*_data=0.
- in_ready = !full of the FIFO selected by in_sel. It is combinational on in_sel and the registered full flags. It does not depend on in_valid or on out*_ready.
- Input transfer: in_valid && in_ready at a rising edge pushes in_data into the FIFO selected by in_sel.
- Output transfer: outN_valid && outN_ready at a rising edge pops channel N.
- Latency: a word accepted at edge k is visible on outN_data with outN_valid=1 after edge k. No combinational input-to-output path.
- outN_data always shows the FIFO head. Its value is don't-care while outN_valid=0, but it holds its last value; it is not X after reset.
- Ordering: strict FIFO order per channel. No ordering relation between channels.
- Full: no accept into a full FIFO, even if that channel pops in the same cycle. in_ready rises on the cycle after the pop.
- Empty: outN_valid=0. Asserting outN_ready has no effect.
- Simultaneous push and pop on the same non-full, non-empty channel: level unchanged; both pointers advance.
- Push to one channel while popping the other: independent.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level = writes - reads, range 0..DEPTH. full = (level==DEPTH); empty = (level==0).
- in_sel is sampled only when a transfer occurs. Changing in_sel while in_valid=1 and in_ready=0 is legal: in_ready re-evaluates for the new channel.
- Reset asserted mid-stream: contents are discarded immediately. Outputs reach their reset values without waiting for a clock edge.

Decomposition:
- Shared package (demux_pkg): constants CH0=1'b0 and CH1=1'b1, plus the default WIDTH and DEPTH.
- One natural sub-module: stream_fifo (parameters WIDTH, DEPTH).
  - Ports: clk, rst_n, push, push_data, pop, head_data, empty, full, level.
  - Instantiated twice.
- Top level contains only the select-steering logic and in_ready generation.

Test Plan:
- Reset then idle -> out0_valid=0, out1_valid=0, levels 0, in_ready=1 for both sel values.
- Push 8'hA1 sel=0, then 8'hB2 sel=1, consumers ready -> 8'hA1 on out0 one cycle after acceptance, then 8'hB2 on out1; levels return to 0.
- Hold out0_ready=0, push 5 words to ch0 (DEPTH=4) -> first 4 accepted; in_ready=0 on the 5th. Meanwhile a sel=1 word 8'h55 is accepted and appears on out1.
- Ch0 full, pulse out0_ready for one cycle while offering a ch0 word -> pop occurs, push refused that cycle, in_ready=1 the next cycle, word then accepted.
- Stream 0x00..0x0F alternating sel with random out*_ready -> each channel emits its 8 words in order (ch0: evens, ch1: odds), none lost or duplicated, across pointer wrap.
- Drop rst_n asynchronously with both FIFOs at level 2 -> valids and levels go to 0 before the next edge; after release the first new word is the next output.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 1:2 stream demultiplexer: channel encodings and default sizing.
package demux_pkg;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with a registered head word and occupancy level.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module stream_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // Pointers wrap naturally because DEPTH is a power of two.
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage array is reset as well, so head_data reads 0 rather than X out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/demux2_stream.sv
// Registered 1:2 stream demultiplexer: steers each accepted word into the
// per-channel FIFO chosen by in_sel; each channel drains independently.
module demux2_stream
    import demux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [LW-1:0]    out0_level,
    output logic [LW-1:0]    out1_level
);

    logic full0, full1;
    logic empty0, empty1;
    logic push0, push1;
    logic accept;

    // in_ready looks only at the selected channel's registered full flag.
    always_comb begin
        in_ready = 1'b0;
        case (in_sel)
            CH0:     in_ready = !full0;
            CH1:     in_ready = !full1;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign push0  = accept && (in_sel == CH0);
    assign push1  = accept && (in_sel == CH1);

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (in_data),
        .pop       (out0_ready),
        .head_data (out0_data),
        .empty     (empty0),
        .full      (full0),
        .level     (out0_level)
    );

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (in_data),
        .pop       (out1_ready),
        .head_data (out1_data),
        .empty     (empty1),
        .full      (full1),
        .level     (out1_level)
    );

endmodule

// File: tb/tb_demux2_stream.sv
// Self-checking bench for demux2_stream: queue-based reference model,
// directed scenarios plus a randomized alternating-select stream.
module tb_demux2_stream;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_sel = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out0_data, out1_data;
    logic          out0_valid, out1_valid;
    logic          out0_ready = 1'b0, out1_ready = 1'b0;
    logic [LW-1:0] out0_level, out1_level;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] q0[$], q1[$];
    logic [W-1:0] got0[$], got1[$];

    always #5 clk = ~clk;

    demux2_stream #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out0_level (out0_level),
        .out1_level (out1_level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check DUT against the model at the falling edge, then
    // apply the transfers the model predicts at the rising edge.
    task automatic cycle(output bit accepted);
        bit exp_rdy, pop0, pop1;
        logic [W-1:0] d;
        logic s;
        @(negedge clk);
        exp_rdy = in_sel ? (q1.size() < D) : (q0.size() < D);
        check("in_ready",   in_ready,   exp_rdy);
        check("out0_valid", out0_valid, q0.size() != 0);
        check("out1_valid", out1_valid, q1.size() != 0);
        check("out0_level", out0_level, q0.size());
        check("out1_level", out1_level, q1.size());
        if (q0.size() != 0) check("out0_data", out0_data, q0[0]);
        if (q1.size() != 0) check("out1_data", out1_data, q1[0]);
        accepted = in_valid && exp_rdy;
        pop0 = out0_ready && (q0.size() != 0);
        pop1 = out1_ready && (q1.size() != 0);
        d = in_data;
        s = in_sel;
        @(posedge clk);
        if (pop0) got0.push_back(q0.pop_front());
        if (pop1) got1.push_back(q1.pop_front());
        if (accepted) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
        #1;
    endtask

    task automatic offer(input logic [W-1:0] d, input logic s, output bit accepted);
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        cycle(accepted);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int budget;
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        budget = 0;
        while ((q0.size() != 0 || q1.size() != 0) && budget < 50) begin
            cycle(acc);
            budget++;
        end
        check("drain_done", (q0.size() == 0 && q1.size() == 0), 1);
    endtask

    initial begin
        bit acc;
        int idx, budget;
        logic [W-1:0] e0[$], e1[$];

        // Reset then idle
        #12;
        check("rst_out0_valid", out0_valid, 0);
        check("rst_out1_valid", out1_valid, 0);
        check("rst_out0_level", out0_level, 0);
        check("rst_out1_level", out1_level, 0);
        check("rst_out0_data",  out0_data,  0);
        check("rst_out1_data",  out1_data,  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_sel = 1'b0;
        cycle(acc);
        in_sel = 1'b1;
        cycle(acc);

        // Basic routing with consumers ready
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        offer(8'hA1, 1'b0, acc);
        check("a1_accepted", acc, 1);
        check("a1_on_out0", out0_data, 8'hA1);
        check("a1_valid", out0_valid, 1);
        offer(8'hB2, 1'b1, acc);
        check("b2_accepted", acc, 1);
        check("b2_on_out1", out1_data, 8'hB2);
        cycle(acc);
        cycle(acc);
        check("basic_level0", out0_level, 0);
        check("basic_level1", out1_level, 0);

        // Fill ch0 with consumer stalled; ch1 still flows
        out0_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(W'(8'h10 + i), 1'b0, acc);
            check("fill_accept", acc, (i < D) ? 1 : 0);
        end
        in_sel = 1'b0;
        #1;
        check("full_in_ready", in_ready, 0);
        offer(8'h55, 1'b1, acc);
        check("ch1_while_ch0_full", acc, 1);
        check("ch1_55_data", out1_data, 8'h55);

        // Pop on full ch0 while offering: push refused, then accepted
        out0_ready = 1'b1;
        offer(8'h77, 1'b0, acc);
        check("full_pop_refuse", acc, 0);
        out0_ready = 1'b0;
        in_sel = 1'b0;
        #1;
        check("ready_after_pop", in_ready, 1);
        offer(8'h77, 1'b0, acc);
        check("after_pop_accept", acc, 1);
        drain();

        // Randomized stream 0x00..0x0F with alternating select
        got0.delete();
        got1.delete();
        idx = 0;
        budget = 0;
        while ((idx < 16 || q0.size() != 0 || q1.size() != 0) && budget < 400) begin
            in_valid   = (idx < 16);
            in_data    = W'(idx);
            in_sel     = idx[0];
            out0_ready = ($urandom_range(0, 99) < 40);
            out1_ready = ($urandom_range(0, 99) < 40);
            cycle(acc);
            if (acc) idx++;
            budget++;
        end
        in_valid = 1'b0;
        check("stream_done", budget < 400, 1);
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) e0.push_back(W'(i));
            else            e1.push_back(W'(i));
        end
        check("stream_cnt0", got0.size(), 8);
        check("stream_cnt1", got1.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got0.size()) check("stream_ch0_word", got0[i], e0[i]);
            if (i < got1.size()) check("stream_ch1_word", got1[i], e1[i]);
        end

        // Asynchronous reset with both FIFOs at level 2
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        offer(8'h21, 1'b0, acc);
        offer(8'h31, 1'b1, acc);
        offer(8'h22, 1'b0, acc);
        offer(8'h32, 1'b1, acc);
        check("pre_rst_level0", out0_level, 2);
        check("pre_rst_level1", out1_level, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out0_valid", out0_valid, 0);
        check("arst_out1_valid", out1_valid, 0);
        check("arst_out0_level", out0_level, 0);
        check("arst_out1_level", out1_level, 0);
        check("arst_out0_data",  out0_data,  0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        offer(8'hC3, 1'b0, acc);
        check("post_rst_accept", acc, 1);
        check("post_rst_data", out0_data, 8'hC3);
        offer(8'hD4, 1'b1, acc);
        check("post_rst_data1", out1_data, 8'hD4);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
